// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the accumulator micro-sequencer: opcodes, FSM states,
// ALU operation codes and small decode helpers.
package micro_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_DONE
  } state_e;

  // Opcodes whose operand is a RAM address read before execution.
  function automatic logic needs_mem(input logic [3:0] op);
    return op inside {OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  // Opcodes A..E are unassigned; they run as NOP but flag the program.
  function automatic logic is_illegal(input logic [3:0] op);
    return op inside {[4'hA:4'hE]};
  endfunction

endpackage

// File: rtl/micro_sequencer.sv
// Accumulator instruction sequencer: fetches from a registered ROM, drives the
// external ALU and data RAM, and reports busy/done/illegal to the top level.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   prog_addr,
  input  logic [ADDR_W+3:0]   prog_data,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [1:0]          alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_dout,
  output logic [DATA_W-1:0]   acc_out,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W+3:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                illegal_q, illegal_d;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic [3:0]          fetched_op;

  assign opcode     = ir_q[ADDR_W+:4];
  assign operand    = ir_q[ADDR_W-1:0];
  assign fetched_op = prog_data[ADDR_W+:4];

  // Next-state and architectural register updates for each sequencer state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d      = '0;
          acc_d     = '0;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // ir is not loaded yet, so the branch decision looks at the ROM word.
        ir_d    = prog_data;
        pc_d    = pc_q + 1'b1;
        state_d = needs_mem(fetched_op) ? S_MEM : S_EXEC;
      end
      S_MEM: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LDI: acc_d = DATA_W'(operand);
          OP_LD:  acc_d = ram_dout;
          OP_ADD, OP_SUB, OP_AND, OP_OR: acc_d = alu_result;
          OP_JMP: pc_d = operand;
          OP_JZ: begin
            if (acc_q == '0) pc_d = operand;
          end
          OP_HLT: state_d = S_DONE;
          default: begin
            if (is_illegal(opcode)) illegal_d = 1'b1;
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      acc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs decode straight from registers so reset clears ram_we immediately.
  always_comb begin
    prog_addr = pc_q;
    alu_a     = acc_q;
    alu_b     = ram_dout;
    alu_op    = opcode[1:0];
    ram_addr  = operand;
    ram_din   = acc_q;
    ram_we    = (state_q == S_EXEC) && (opcode == OP_ST);
    acc_out   = acc_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with behavioural ROM, RAM and ALU models.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] alu_a, alu_b, alu_result, ram_addr, ram_din, ram_dout, acc_out;
  logic [1:0] alu_op;
  logic       ram_we, busy, done, illegal;

  logic [7:0] rom [16];
  logic [3:0] mem [16];

  int errors = 0;
  int checks = 0;

  micro_sequencer #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .acc_out    (acc_out),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Registered program ROM.
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Registered-read data RAM with write strobe.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  // Combinational ALU.
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Pulse start, then count edges until done (bounded).
  task automatic run_prog(output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", done, 1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] ai;
    logic [3:0] mv;
    logic [3:0] exp_acc;
    logic [3:0] exp_mem;
    logic       exp_ill;
    int         exp_cyc;
  } vec_t;

  vec_t tbl [9];
  int   cyc;
  int   busy_low;

  initial begin
    // op, acc init, mem value, expected acc, expected RAM[E], illegal, cycles
    tbl[0] = '{4'h4, 4'h7, 4'h9, 4'h0, 4'h9, 1'b0, 16};  // ADD wraps
    tbl[1] = '{4'h5, 4'h3, 4'h5, 4'hE, 4'h5, 1'b0, 16};  // SUB wraps
    tbl[2] = '{4'h6, 4'hC, 4'hA, 4'h8, 4'hA, 1'b0, 16};  // AND
    tbl[3] = '{4'h7, 4'h5, 4'hA, 4'hF, 4'hA, 1'b0, 16};  // OR
    tbl[4] = '{4'h2, 4'h3, 4'h6, 4'h6, 4'h6, 1'b0, 16};  // LD
    tbl[5] = '{4'h1, 4'h3, 4'h6, 4'hE, 4'h6, 1'b0, 15};  // LDI operand E
    tbl[6] = '{4'hC, 4'h4, 4'h1, 4'h4, 4'h1, 1'b1, 15};  // illegal acts as NOP
    tbl[7] = '{4'h0, 4'h4, 4'h1, 4'h4, 4'h1, 1'b0, 15};  // NOP, illegal cleared
    tbl[8] = '{4'h3, 4'h2, 4'h6, 4'h2, 4'h2, 1'b0, 15};  // ST overwrites RAM[E]

    rst   = 1'b1;
    start = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_acc", acc_out, 0);
    check("rst_pc", prog_addr, 0);
    check("rst_we", ram_we, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: LDI mv; ST E; LDI ai; <op> E; HLT
    for (int i = 0; i < 9; i++) begin
      clear_rom();
      rom[0] = {4'h1, tbl[i].mv};
      rom[1] = 8'h3E;
      rom[2] = {4'h1, tbl[i].ai};
      rom[3] = {tbl[i].op, 4'hE};
      rom[4] = 8'hF0;
      run_prog(cyc);
      check($sformatf("vec%0d_cycles", i), cyc, tbl[i].exp_cyc);
      check($sformatf("vec%0d_acc", i), acc_out, tbl[i].exp_acc);
      check($sformatf("vec%0d_illegal", i), illegal, tbl[i].exp_ill);
      check($sformatf("vec%0d_mem", i), mem[14], tbl[i].exp_mem);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_idle", i), busy, 0);
    end

    // LDI 5; ST 3; LDI 2; ADD 3; ST 4; HLT
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h33; rom[2] = 8'h12;
    rom[3] = 8'h43; rom[4] = 8'h34; rom[5] = 8'hF0;
    run_prog(cyc);
    check("prog2_cycles", cyc, 19);
    check("prog2_acc", acc_out, 7);
    check("prog2_mem3", mem[3], 5);
    check("prog2_mem4", mem[4], 7);
    @(posedge clk); #1;
    check("prog2_done_pulse", done, 0);

    // Preset RAM[3]=9, then reset in the middle of ST 3.
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h33; rom[2] = 8'hF0;
    run_prog(cyc);
    check("pre_mem3", mem[3], 9);
    @(posedge clk); #1;
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h33; rom[2] = 8'hF0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!ram_we && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("st_we_seen", ram_we, 1);
    check("st_acc_before", acc_out, 5);
    rst = 1'b1;
    #1;
    check("rstmid_we", ram_we, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_pc", prog_addr, 0);
    check("rstmid_acc", acc_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_mem3", mem[3], 9);
    @(posedge clk); #1;

    // LDI 2; ST 0; LDI 1; SUB 0; HLT
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h30; rom[2] = 8'h11; rom[3] = 8'h50; rom[4] = 8'hF0;
    run_prog(cyc);
    check("sub_wrap_acc", acc_out, 4'hF);
    check("sub_wrap_cycles", cyc, 16);
    @(posedge clk); #1;

    // LDI 0; JZ 7; skipped LDI F words; word 7 = HLT
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h97;
    for (int i = 2; i < 7; i++) rom[i] = 8'h1F;
    rom[7] = 8'hF0;
    run_prog(cyc);
    check("jz_taken_cycles", cyc, 9);
    check("jz_taken_acc", acc_out, 0);
    @(posedge clk); #1;

    // LDI 1; JZ 5; HLT; word 5 = LDI F
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h95; rom[2] = 8'hF0; rom[5] = 8'h1F;
    run_prog(cyc);
    check("jz_not_taken_cycles", cyc, 9);
    check("jz_not_taken_acc", acc_out, 1);
    @(posedge clk); #1;

    // Illegal opcode B then HLT; next start clears the flag.
    clear_rom();
    rom[0] = 8'hB0; rom[1] = 8'hF0;
    run_prog(cyc);
    check("ill_cycles", cyc, 6);
    check("ill_flag", illegal, 1);
    check("ill_acc", acc_out, 0);
    @(posedge clk); #1;
    check("ill_sticky", illegal, 1);
    clear_rom();
    rom[0] = 8'hF0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ill_cleared", illegal, 0);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hlt_only_cycles", cyc, 3);
    @(posedge clk); #1;

    // 16 NOPs, start pulsed mid-run, word 0 becomes HLT before pc wraps.
    clear_rom();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    busy_low = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy) busy_low++;
      start = (cyc == 20);
      if (cyc == 30) rom[0] = 8'hF0;
    end
    start = 1'b0;
    check("wrap_done", done, 1);
    check("wrap_cycles", cyc, 51);
    check("wrap_busy_low", busy_low, 0);
    @(posedge clk); #1;
    check("wrap_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Accumulator-based instruction sequencer driving the 4-bit ALU and the 16x4 data RAM of the microcontroller.
- Fetches 8-bit instructions from an external registered program ROM.
- Sequences ALU operand/opcode selection, RAM read/write and program-counter flow.
- Sits between the top-level start/done control and the existing ALU and RAM instances, replacing their direct top-level drive.

Parameters:
DATA_W, 4, accumulator/ALU/RAM data width.
ADDR_W, 4, RAM address, PC and instruction operand width. Instruction width is 4+ADDR_W. Only the defaults are verified.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle request to run the program from PC=0; honoured only in IDLE
prog_addr  output  ADDR_W  program ROM address (= pc)
prog_data  input  4+ADDR_W  ROM word, valid the cycle after prog_addr is presented
alu_a  output  DATA_W  = acc
alu_b  output  DATA_W  = ram_dout
alu_op  output  2  ALU opcode: 00 add, 01 sub, 10 and, 11 or
alu_result  input  DATA_W  combinational ALU result
ram_addr  output  ADDR_W  = ir operand
ram_din  output  DATA_W  = acc
ram_we  output  1  RAM write strobe
ram_dout  input  DATA_W  RAM read data, registered, valid the cycle after ram_addr
acc_out  output  DATA_W  accumulator
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on HLT retirement
illegal  output  1  sticky; set on an opcode in A-E, cleared by start or rst

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, ir=0, acc=0, illegal=0, ram_we=0, done=0, busy=0.
- Instruction format: ir[7:4] opcode, ir[3:0] operand.
  - Opcodes: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 JMP, 9 JZ, F HLT.
  - Opcodes A-E are illegal: executed as NOP and set illegal.
- alu_op = ir[5:4] (ADD..OR map to 00..11). All datapath outputs are combinational from registers and state.
- States and transitions:
  - IDLE: on start, pc<=0, acc<=0, illegal<=0, go to FETCH. Otherwise stay.
  - FETCH: prog_addr=pc, go to DECODE.
  - DECODE: ir<=prog_data, pc<=pc+1 (wraps 15 to 0). Next state is MEM if the opcode is LD/ADD/SUB/AND/OR, else EXEC. Decode is taken from prog_data.
  - MEM: ram_addr presented, go to EXEC.
  - EXEC actions:
    - LDI: acc<=operand.
    - LD: acc<=ram_dout.
    - ADD/SUB/AND/OR: acc<=alu_result, mod 2^DATA_W; SUB wraps.
    - ST: ram_we=1 for exactly this cycle, ram_din=acc.
    - JMP: pc<=operand.
    - JZ: pc<=operand if acc==0, else pc unchanged.
    - HLT: go to DONE.
    - All others: go to FETCH.
  - DONE: done=1, busy=1, go to IDLE.
- Latency:
  - LDI/ST/NOP/JMP/JZ: 3 cycles (FETCH, DECODE, EXEC).
  - Memory-read ops: 4 cycles.
  - HLT: 3 cycles plus 1 DONE cycle.
- start while busy is ignored; it causes no restart and no state change.
- ram_we is never asserted outside EXEC-of-ST; reset during EXEC deasserts it immediately.
- A JMP to its own address loops forever; busy stays high. This is legal, and only rst exits.
- Zero test for JZ uses acc as registered before EXEC.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_NOP..OP_HLT;
  - state encoding: S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_DONE;
  - ALU opcode constants: ALU_ADD/SUB/AND/OR.
- No sub-module is required. Optionally split the next-state/decode logic into seq_decode (combinational: opcode in; needs_mem, is_illegal out).

Test Plan:
1. Reset mid-ST, with rst asserted in EXEC → ram_we drops the same cycle; busy=0, pc=0, acc=0; the RAM location keeps its old value.
2. Program LDI 5; ST 3; LDI 2; ADD 3; ST 4; HLT → RAM[3]=5, RAM[4]=7, acc_out=7. done pulses one cycle, 19 cycles after the start cycle.
3. Program LDI 2; ST 0; LDI 1; SUB 0; HLT → acc=F (wrap). Then LDI 0; JZ 7 with word 7=HLT → pc jumps, and intervening words are not executed.
4. Program LDI 1; JZ 5 (at 1); HLT (at 2); word 5=LDI F → JZ not taken; HLT retires with acc=1.
5. Program word 0=opcode B, word 1=HLT → illegal=1 at done, acc unchanged. A following start clears illegal.
6. start pulsed during a running program, and pc wrap with 16 NOPs then word 0=HLT → no restart; execution wraps 15 to 0 and halts after 17 instructions.
